// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus bus types: request and response beats used by every cbus master and slave.
// Latency: n/a (types only).
// Backpressure: n/a (types only); flow control is carried in cbus_resp_t.ready.
//
// cbus_req_t  : valid, we, addr, wdata, len (beats-1 of the burst)
// cbus_resp_t : ready (beat accepted/returned), last (final beat), rdata
package cbus_rr_arbiter_pkg;

   localparam int CBUS_AW = 32;
   localparam int CBUS_DW = 32;
   localparam int CBUS_LW = 4;

   typedef struct packed {
      logic               valid;
      logic               we;
      logic [CBUS_AW-1:0] addr;
      logic [CBUS_DW-1:0] wdata;
      logic [CBUS_LW-1:0] len;
   } cbus_req_t;

   typedef struct packed {
      logic               ready;
      logic               last;
      logic [CBUS_DW-1:0] rdata;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Round-robin search: first set bit of valid starting at (last+1) mod N, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on found/idx.
//
// Ports:
//   valid [N-1:0]  request vector
//   last  [IW-1:0] index granted most recently; search begins just after it
//   found          any bit of valid set
//   idx   [IW-1:0] winning index (0 when found is low)
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   localparam logic [IW:0] LP_N = (IW+1)'(N);

   always_comb begin : p_search
      logic [IW:0] w_sum;
      found = 1'b0;
      idx   = '0;
      w_sum = '0;
      // k runs 1..N so the previous winner is examined last.
      // last <= N-1 and k <= N keep the sum below 2N, so one subtract wraps it.
      for (int k = 1; k <= N; k++) begin
         w_sum = {1'b0, last} + (IW+1)'(k);
         if (w_sum >= LP_N) begin
            w_sum = w_sum - LP_N;
         end
         if (!found && valid[w_sum[IW-1:0]]) begin
            found = 1'b1;
            idx   = w_sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cbus arbiter, round-robin, grant locked for a whole burst (until oresp.last).
// Latency: 1 cycle from request to grant; one idle arbitration cycle between bursts.
// Backpressure: oresp.ready is passed straight to the granted requester; the others see all-zero responses.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   ireqs [N]            requester requests (0 = instruction side, 1 = data side)
//   iresps[N]            requester responses, only the granted one is non-zero
//   oreq                 downstream request (mux of the granted requester)
//   oresp                downstream response
//   busy                 a grant is active
//   grant_idx            current or most recent grant
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          resetn,
   input  cbus_req_t     ireqs  [N],
   output cbus_resp_t    iresps [N],
   output cbus_req_t     oreq,
   input  cbus_resp_t    oresp,
   output logic          busy,
   output logic [IW-1:0] grant_idx
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t        r_state;
   logic [IW-1:0] r_sel;
   logic [IW-1:0] r_last;
   logic          r_busy;

   logic [N-1:0]  w_valid;
   logic          w_found;
   logic [IW-1:0] w_idx;

   always_comb begin
      w_valid = '0;
      for (int i = 0; i < N; i++) begin
         w_valid[i] = ireqs[i].valid;
      end
   end

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .valid (w_valid),
      .last  (r_last),
      .found (w_found),
      .idx   (w_idx)
   );

   // Reset leaves last at N-1 so requester 0 wins the first arbitration.
   // Once granted, nothing but ready&&last (or reset) releases the grant,
   // even if the owner drops valid mid-burst.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_last  <= IW'(N-1);
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state <= ST_GRANT;
                  r_sel   <= w_idx;
                  r_last  <= w_idx;
                  r_busy  <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (oresp.ready && oresp.last) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Idle state drives nothing downstream and nothing back; a stray
   // oresp.ready while idle therefore never reaches a requester.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < N; i++) begin
         iresps[i] = '0;
      end
      if (r_state == ST_GRANT) begin
         oreq          = ireqs[r_sel];
         iresps[r_sel] = oresp;
      end
   end

   assign busy      = r_busy;
   assign grant_idx = r_sel;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter (N=4): directed scenarios, a behavioural round-robin model
// checked against the DUT every cycle, plus literal expectations for grant order and gaps.
// Responder and requesters are driven from the bench's own model state.
module tb_cbus_rr_arbiter;
   import cbus_rr_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk    = 1'b0;
   logic          resetn = 1'b0;
   cbus_req_t     ireqs  [N];
   cbus_resp_t    iresps [N];
   cbus_req_t     oreq;
   cbus_resp_t    oresp;
   logic          busy;
   logic [IW-1:0] grant_idx;

   cbus_rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_grant = 1'b0;
   int m_sel   = 0;
   int m_last  = N-1;
   int m_c;
   bit m_found;
   int bcnt = 0;
   int rcnt = 0;
   int mlog[$];

   // stimulus control
   int done_cnt [N] = '{default: 0};
   int req_add  [N] = '{default: 0};
   int beats    = 1;
   int rdelay   = 0;
   bit idle_rdy = 1'b0;
   bit chk_en   = 1'b0;
   int cyc      = 0;

   // DUT observation
   int dlog[$];
   int gaps[$];
   bit in_run    = 1'b0;
   bit prev_busy = 1'b0;
   int idle_cnt  = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // exp holds n 4-bit entries, first entry in the most significant nibble
   task automatic check_seq(input string nm, input int q[$], input int st, input int n, input logic [31:0] exp);
      checks++;
      if (q.size() - st != n) begin
         errors++;
         $display("FAIL %s_len actual=%0d required=%0d", nm, q.size() - st, n);
      end else begin
         for (int j = 0; j < n; j++) begin
            checks++;
            if (q[st+j] != int'(exp[4*(n-1-j) +: 4])) begin
               errors++;
               $display("FAIL %s[%0d] actual=%0d required=%0d", nm, j, q[st+j], exp[4*(n-1-j) +: 4]);
            end
         end
      end
   endtask

   function automatic bit all_done();
      for (int i = 0; i < N; i++) begin
         if (req_add[i] > done_cnt[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Model: round-robin from (last+1) mod N, one-cycle pick, burst lock until ready&&last.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_grant = 1'b0;
         m_sel   = 0;
         m_last  = N-1;
         bcnt    = 0;
         rcnt    = 0;
      end else if (!m_grant) begin
         m_found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            m_c = (m_last + k) % N;
            if (!m_found && ireqs[m_c].valid) begin
               m_found = 1'b1;
               m_sel   = m_c;
            end
         end
         if (m_found) begin
            m_grant = 1'b1;
            m_last  = m_sel;
            bcnt    = 0;
            rcnt    = 0;
            mlog.push_back(m_sel);
         end
      end else begin
         if (oresp.ready && oresp.last) begin
            m_grant = 1'b0;
            done_cnt[m_sel]++;
         end else begin
            bcnt++;
            if (oresp.ready) rcnt++;
         end
      end
   end

   // Requesters and responder, updated shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         ireqs[i].valid = (req_add[i] > done_cnt[i]);
         ireqs[i].we    = (i % 2 == 1);
         ireqs[i].addr  = 32'h1000_0000 + 32'(i * 32'h100) + 32'(cyc);
         ireqs[i].wdata = 32'hA500_0000 + 32'(i << 16) + 32'(cyc);
         ireqs[i].len   = 4'(beats - 1);
      end
      if (m_grant) begin
         oresp.ready = (bcnt >= rdelay);
         oresp.last  = (bcnt >= rdelay) && (rcnt == beats - 1);
      end else begin
         oresp.ready = idle_rdy;
         oresp.last  = idle_rdy;
      end
      oresp.rdata = 32'hD000_0000 + 32'(cyc);
   end

   // Per-cycle compare against the model, plus grant/gap logging.
   always @(negedge clk) begin
      cbus_req_t  exp_req;
      cbus_resp_t exp_rsp;
      cyc++;
      if (chk_en) begin
         check("busy", 128'(busy), 128'(m_grant));
         check("grant_idx", 128'(grant_idx), 128'(m_sel));
         exp_req = m_grant ? ireqs[m_sel] : '0;
         check("oreq", 128'(oreq), 128'(exp_req));
         for (int i = 0; i < N; i++) begin
            exp_rsp = (m_grant && i == m_sel) ? oresp : '0;
            check($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(exp_rsp));
         end
      end
      if (!resetn) begin
         in_run    = 1'b0;
         prev_busy = 1'b0;
         idle_cnt  = 0;
      end else begin
         if (busy === 1'b1 && !prev_busy) begin
            dlog.push_back(int'(grant_idx));
            if (in_run) gaps.push_back(idle_cnt);
            in_run   = 1'b1;
            idle_cnt = 0;
         end else if (busy !== 1'b1 && in_run) begin
            idle_cnt++;
         end
         prev_busy = (busy === 1'b1);
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_grant_idx", 128'(grant_idx), 128'(0));
      check("rst_oreq", 128'(oreq), 128'(0));
      resetn = 1'b1;
   endtask

   task automatic wait_grant(input string nm, input int budget);
      int n = 0;
      while (n < budget) begin
         @(posedge clk); #2;
         if (m_grant) break;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_grant_timeout actual=%0d required<%0d", nm, n, budget);
      end
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      while (n < budget) begin
         @(posedge clk); #2;
         if (!m_grant && all_done()) break;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_done_timeout actual=%0d required<%0d", nm, n, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int s_d, s_g, s_m;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // single data-side transfer, ready/last on the second grant cycle
      beats = 1; rdelay = 1;
      do_reset();
      s_d = dlog.size();
      @(posedge clk);
      req_add[1] = done_cnt[1] + 1;
      @(negedge clk);
      check("s1_busy_before", 128'(busy), 128'(0));
      @(negedge clk);
      check("s1_busy_rise", 128'(busy), 128'(1));
      check("s1_grant_idx", 128'(grant_idx), 128'(1));
      check("s1_iresp0_zero", 128'(iresps[0]), 128'(0));
      @(negedge clk);
      check("s1_busy_beat2", 128'(busy), 128'(1));
      check("s1_iresp1_last", 128'(iresps[1].last), 128'(1));
      @(negedge clk);
      check("s1_busy_fall", 128'(busy), 128'(0));
      check("s1_grant_hold", 128'(grant_idx), 128'(1));
      wait_done("s1", 20);
      check_seq("s1_order", dlog, s_d, 1, 32'h1);

      // both sides valid from reset, 4-beat bursts, two each
      beats = 4; rdelay = 0;
      req_add[0] = done_cnt[0] + 2;
      req_add[1] = done_cnt[1] + 2;
      s_d = dlog.size(); s_g = gaps.size(); s_m = mlog.size();
      do_reset();
      wait_done("s2", 80);
      check_seq("s2_order", dlog, s_d, 4, 32'h0101);
      check_seq("s2_gaps", gaps, s_g, 3, 32'h111);
      check_seq("s2_model_order", mlog, s_m, 4, 32'h0101);

      // requester 1 arrives at beat 2 of requester 0's burst: no preemption
      do_reset();
      s_d = dlog.size(); s_g = gaps.size();
      @(posedge clk);
      req_add[0] = done_cnt[0] + 1;
      wait_grant("s3", 10);
      req_add[1] = done_cnt[1] + 1;
      @(negedge clk); @(negedge clk);
      check("s3_no_preempt", 128'(grant_idx), 128'(0));
      wait_done("s3", 40);
      check_seq("s3_order", dlog, s_d, 2, 32'h01);
      check_seq("s3_gaps", gaps, s_g, 1, 32'h1);

      // wrap: last=3, requesters 2 and 3 first, then 0 and 2 again
      beats = 2;
      do_reset();
      s_d = dlog.size(); s_g = gaps.size(); s_m = mlog.size();
      @(posedge clk);
      req_add[2] = done_cnt[2] + 1;
      req_add[3] = done_cnt[3] + 1;
      wait_grant("s4", 10);
      req_add[0] = done_cnt[0] + 1;
      req_add[2] = req_add[2] + 1;
      wait_done("s4", 60);
      check_seq("s4_order", dlog, s_d, 4, 32'h2302);
      check_seq("s4_gaps", gaps, s_g, 3, 32'h111);
      check_seq("s4_model_order", mlog, s_m, 4, 32'h2302);

      // reset mid-burst of requester 1 while requester 0 waits
      beats = 4; rdelay = 1;
      do_reset();
      s_d = dlog.size(); s_g = gaps.size();
      @(posedge clk);
      req_add[1] = done_cnt[1] + 1;
      wait_grant("s5", 10);
      req_add[0] = done_cnt[0] + 1;
      @(posedge clk); #3;
      check("s5_oreq_vld_pre", 128'(oreq.valid), 128'(1));
      resetn = 1'b0;
      #1;
      check("s5_oreq_vld_async", 128'(oreq.valid), 128'(0));
      check("s5_busy_async", 128'(busy), 128'(0));
      check("s5_iresp1_async", 128'(iresps[1]), 128'(0));
      @(negedge clk); @(negedge clk); #1;
      resetn = 1'b1;
      wait_done("s5", 80);
      check_seq("s5_order", dlog, s_d, 3, 32'h101);
      check_seq("s5_gaps", gaps, s_g, 1, 32'h1);

      // ready/last while idle must be ignored
      beats = 1; rdelay = 0;
      do_reset();
      s_d = dlog.size();
      idle_rdy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s6_idle_busy", 128'(busy), 128'(0));
         check("s6_idle_iresp0", 128'(iresps[0]), 128'(0));
      end
      idle_rdy = 1'b0;
      @(posedge clk);
      req_add[0] = done_cnt[0] + 1;
      wait_done("s6", 20);
      check_seq("s6_order", dlog, s_d, 1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cbus_rr_arbiter.md
CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 Parameter N, default 2: number of requester ports; N SHALL be at least 2.
REQ-002 Parameter IW, default $clog2(N): width of the grant index.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 ireqs  input  cbus_req_t[N]  requester-side requests; index 0 is the instruction side, index 1 is the data side.
REQ-006 iresps  output  cbus_resp_t[N]  per-requester responses.
REQ-007 oreq  output  cbus_req_t  downstream request toward memory/translation.
REQ-008 oresp  input  cbus_resp_t  downstream response.
REQ-009 busy  output  1  high while a transaction is granted.
REQ-010 grant_idx  output  IW  index of the current or most recent grant.

Function
REQ-011 FSM states SHALL be IDLE and GRANT.
REQ-012 IDLE: the block SHALL pick the first valid requester in round-robin order, starting at (last+1) mod N.
REQ-013 On a pick in IDLE, the block SHALL register sel, enter GRANT next cycle, and set last := sel in the same cycle; arbitration latency is exactly 1 cycle.
REQ-014 IDLE with no valid requester: state, sel and last SHALL hold.
REQ-015 GRANT: oreq SHALL equal ireqs[sel] combinationally; iresps[sel] SHALL equal oresp; all other iresps SHALL be all-zero.
REQ-016 IDLE: oreq and every iresps entry SHALL be all-zero (valid=0, ready=0, last=0).
REQ-017 GRANT to IDLE SHALL occur on the cycle oresp.ready && oresp.last is sampled high.
REQ-018 The cycle after that return to IDLE SHALL be an arbitration cycle; back-to-back transactions SHALL therefore have exactly one idle cycle between them.
REQ-019 The grant SHALL be locked for the whole burst; new or higher-index requests SHALL NOT preempt it.
REQ-020 If ireqs[sel].valid drops during GRANT (protocol violation), the grant SHALL be held until oresp.last; no recovery is required.
REQ-021 If all N requesters are valid continuously, the grants SHALL rotate 0,1,...,N-1,0; no requester waits more than N-1 transactions.
REQ-022 Round-robin wrap: when last = N-1, the search SHALL start at 0.
REQ-023 oresp.ready while in IDLE SHALL be ignored.
REQ-024 busy SHALL be 1 exactly when state = GRANT; grant_idx SHALL equal sel.

Reset
REQ-025 While resetn = 0, the block SHALL asynchronously set state := IDLE, sel := 0, and last := N-1, so that requester 0 wins the first arbitration.
REQ-026 During reset, outputs SHALL be: busy=0, grant_idx=0, oreq all-zero, iresps all-zero.
REQ-027 Reset asserted mid-burst SHALL abandon the transaction; after release, arbitration SHALL restart from requester 0.

Structure
REQ-028 cbus_req_t and cbus_resp_t SHALL come from the existing shared common package; no new bus types SHALL be added.
REQ-029 The state enum SHALL be local to the module.
REQ-030 A single combinational sub-module, rr_pick, SHALL be used: inputs valid[N] and last; outputs found and idx.
REQ-031 The rest of the design SHALL be the FSM plus the output muxing; the expected size is 120-250 lines.

Verification
REQ-032 Reset release, then ireqs[1] valid with len=0 and ready/last on the second GRANT cycle -> busy rises 1 cycle after valid; grant_idx=1; iresps[0] stays zero; busy falls the cycle after last.
REQ-033 Both requesters valid from reset, each doing 4-beat bursts -> grant order 0,1,0,1; exactly 1 idle cycle between bursts.
REQ-034 Requester 0 in a 4-beat burst while requester 1 asserts valid at beat 2 -> no preemption; requester 1 granted 2 cycles after beat 4's last.
REQ-035 N=4 with last=3 and requesters 2 and 3 valid -> requester 2 granted; next grant goes to 3; wrap from 3 returns to 0.
REQ-036 resetn pulsed low mid-burst -> oreq.valid=0 immediately (asynchronous); after release with both valid, requester 0 is granted.
REQ-037 oresp.ready=1 while IDLE -> no state change; all iresps remain zero.
